// File: rtl/risc_i_unit.sv
// Fetch stage of the 13-bit RISC datapath: a free-running 5-bit PC and a 13-bit instruction register.
// Optional decode outputs derived from ir are enabled by defining RISC_IUNIT_DECODE_EN.
module risc_i_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] instruction,
   output logic [4:0]  pc,
   output logic [12:0] ir
`ifdef RISC_IUNIT_DECODE_EN
   ,
   output logic [3:0]  opcode,
   output logic [2:0]  rd,
   output logic [2:0]  rs,
   output logic [2:0]  rt,
   output logic [15:0] op_onehot,
   output logic        illegal
`endif
);

   // rst_n is active-high despite its name; PC wraps modulo 32 with no flag.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc <= 5'h00;
         ir <= 13'h0000;
      end else begin
         pc <= pc + 5'd1;
         ir <= instruction;
      end
   end

`ifdef RISC_IUNIT_DECODE_EN
   // Decode looks only at the registered ir so downstream logic never sees memory-bus glitches.
   always_comb begin
      opcode            = ir[12:9];
      rd                = ir[8:6];
      rs                = ir[5:3];
      rt                = ir[2:0];
      op_onehot         = 16'h0000;
      op_onehot[opcode] = 1'b1;
      illegal           = (opcode == 4'd0) || (opcode > 4'd13);
   end
`endif

endmodule

// File: tb/tb_risc_i_unit.sv
// Self-checking bench for risc_i_unit: reset, fetch sequence, PC wrap, async reset and optional decode.
module tb_risc_i_unit;

   logic        clk;
   logic        rst_n;
   logic [12:0] instruction;
   logic [4:0]  pc;
   logic [12:0] ir;
`ifdef RISC_IUNIT_DECODE_EN
   logic [3:0]  opcode;
   logic [2:0]  rd, rs, rt;
   logic [15:0] op_onehot;
   logic        illegal;
`endif

   int checks = 0;
   int errors = 0;
   logic [4:0]  model_pc;
   logic [17:0] exp_q[$];

   risc_i_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instruction (instruction),
      .pc          (pc),
      .ir          (ir)
`ifdef RISC_IUNIT_DECODE_EN
      ,
      .opcode      (opcode),
      .rd          (rd),
      .rs          (rs),
      .rt          (rt),
      .op_onehot   (op_onehot),
      .illegal     (illegal)
`endif
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Hold reset over several edges with a nonzero word on the bus, then release between edges.
   task automatic apply_reset();
      rst_n       = 1'b1;
      instruction = 13'h0208;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_pc", {27'd0, pc}, 32'd0);
         check("rst_ir", {19'd0, ir}, 32'd0);
      end
      rst_n    = 1'b0;
      model_pc = 5'd0;
      exp_q.delete();
   endtask

   // Drive one word, push the expected {pc, ir}, then pop and compare after the edge.
   task automatic step(input logic [12:0] word, input string tag);
      logic [17:0] exp;
      instruction = word;
      model_pc    = model_pc + 5'd1;
      exp_q.push_back({model_pc, word});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check({tag, "_underflow"}, 32'd1, 32'd0);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_pc"}, {27'd0, pc}, {27'd0, exp[17:13]});
         check({tag, "_ir"}, {19'd0, ir}, {19'd0, exp[12:0]});
      end
   endtask

   logic [12:0] seq_words [12];

   initial begin
      seq_words = '{13'h05f1, 13'h06aa, 13'h08e3, 13'h0b24, 13'h0d45, 13'h0f86,
                    13'h11c7, 13'h1200, 13'h1441, 13'h1682, 13'h18c3, 13'h1b04};
      rst_n       = 1'b1;
      instruction = 13'h0000;
      model_pc    = 5'd0;
      #2;
      check("rst_async_pc", {27'd0, pc}, 32'd0);

      apply_reset();
`ifdef RISC_IUNIT_DECODE_EN
      check("rst_onehot", {16'd0, op_onehot}, 32'h0001);
      check("rst_illegal", {31'd0, illegal}, 32'd1);
`endif

      // first fetch and the twelve-word sequence
      step(13'h0208, "first");
      check("first_ir", {19'd0, ir}, 32'h0208);
      check("first_pc", {27'd0, pc}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         step(seq_words[i], "seq");
`ifdef RISC_IUNIT_DECODE_EN
         if (i == 0) begin
            check("dec_opcode", {28'd0, opcode}, 32'd2);
            check("dec_rd", {29'd0, rd}, 32'd7);
            check("dec_rs", {29'd0, rs}, 32'd6);
            check("dec_rt", {29'd0, rt}, 32'd1);
            check("dec_illegal", {31'd0, illegal}, 32'd0);
            check("dec_onehot", {16'd0, op_onehot}, 32'h0004);
         end
`endif
      end
      check("seq_pc13", {27'd0, pc}, 32'd13);

`ifdef RISC_IUNIT_DECODE_EN
      step(13'h1e00, "dec15");
      check("dec15_opcode", {28'd0, opcode}, 32'd15);
      check("dec15_illegal", {31'd0, illegal}, 32'd1);
      check("dec15_onehot", {16'd0, op_onehot}, 32'h8000);
`endif

      // wrap: 32 cycles from reset with random words
      apply_reset();
      for (int i = 0; i < 32; i++) begin
         step(13'($urandom_range(0, 8191)), "wrap");
         if (i == 30) check("wrap_pc1f", {27'd0, pc}, 32'h1f);
         if (i == 31) check("wrap_pc00", {27'd0, pc}, 32'h00);
      end

      // asynchronous reset between edges at pc=7
      apply_reset();
      for (int i = 0; i < 7; i++) step(13'($urandom_range(1, 8191)) | 13'h0001, "pre_async");
      check("async_pc7", {27'd0, pc}, 32'd7);
      #2;
      rst_n = 1'b1;
      #1;
      check("async_pc", {27'd0, pc}, 32'd0);
      check("async_ir", {19'd0, ir}, 32'd0);
      @(posedge clk);
      #1;
      check("async_hold_pc", {27'd0, pc}, 32'd0);
      rst_n    = 1'b0;
      model_pc = 5'd0;
      step(13'h0d45, "post_async");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/risc_i_unit.md
# risc_i_unit

Instruction unit (fetch stage) of the 13-bit RISC datapath. Holds the 5-bit program counter that addresses instruction memory and the 13-bit instruction register that latches the word returned for that address. Sits between instruction memory and the decode/ALU control logic; `ir` feeds the decoder, `pc` drives the memory address bus.

## Interface
Parameters: none (widths fixed: instruction 13 bits, PC 5 bits).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous reset, active-high: `1` = reset asserted, `0` = run. The name is kept for codebase consistency; polarity is high.
- `instruction`  input  13  instruction word from instruction memory for address `pc`.
- `pc`  output  5  program counter, registered.
- `ir`  output  13  instruction register, registered.
- With `RISC_IUNIT_DECODE_EN` only:
  - `opcode`  output  4  `ir[12:9]`.
  - `rd`  output  3  `ir[8:6]`.
  - `rs`  output  3  `ir[5:3]`.
  - `rt`  output  3  `ir[2:0]`.
  - `op_onehot`  output  16  one-hot of `opcode`.
  - `illegal`  output  1  opcode not in 1..13.

## Operation
- One clock domain; one reset.
- Reset:
  - While `rst_n`=1, `pc`=5'h00 and `ir`=13'h0000, independent of `clk`.
  - Deassertion takes effect at the next rising edge.
- Normal cycle (`rst_n`=0), each rising `clk`:
  - `ir` <= `instruction`
  - `pc` <= `pc` + 1
  - Both updates in the same edge.
- No stall, branch or load input; PC advances unconditionally every cycle.
- PC arithmetic is modulo 32: 5'h1F + 1 -> 5'h00, no flag, no stop.
- `ir` captures the word verbatim; no masking or validity check in the core path.
- Instruction format (used by decode option and downstream decoder):
  - `[12:9]` opcode
  - `[8:6]` rd
  - `[5:3]` rs
  - `[2:0]` rt
- Opcodes:
  - 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 inc, 7 dec, 8 not, 9 neg, 10 shr, 11 shl, 12 ror, 13 rol.
  - 0, 14, 15 are illegal.

## Timing
- Latency: a word on `instruction` at a rising edge appears on `ir` immediately after that edge (1 cycle).
- `pc` after the edge is the address of the next word to present.
- Reset assertion mid-cycle clears `pc` and `ir` immediately (asynchronous), overriding any edge in the same instant.
- Reset has priority over the clock when both occur together.
- Outputs are glitch-free register outputs; decode outputs are combinational from `ir` only, never from `instruction`.

## Configuration
- Macro `RISC_IUNIT_DECODE_EN`.
- Defined:
  - Adds the decode ports and logic listed above.
  - `illegal`=1 when `ir[12:9]` is 0, 14 or 15.
  - `op_onehot[opcode]`=1, all other bits 0.
  - During reset, `ir`=0 gives `opcode`=0, `op_onehot`=16'h0001, `illegal`=1.
- Undefined:
  - Decode ports and logic are absent.
  - Only `clk`, `rst_n`, `instruction`, `pc`, `ir` exist.
  - `pc`/`ir` behaviour is identical in both builds.

## Test plan
- Reset: `rst_n`=1 with `instruction`=13'h0208 and clock running -> `pc`=0, `ir`=0 throughout.
- First fetch: release reset, `instruction`=13'h0208 at the first edge -> `ir`=13'h0208, `pc`=1.
- Sequence: present 13'h05f1, 06aa, 08e3, 0b24, 0d45, 0f86, 11c7, 1200, 1441, 1682, 18c3, 1b04 on successive edges -> `ir` tracks each word one cycle later; `pc` reaches 13 after 13 loads.
- Wrap: run 32 cycles from reset -> `pc` goes 5'h1F then 5'h00.
- Async reset mid-run: assert `rst_n` between edges with `pc`=7 -> `pc`=0 and `ir`=0 before the next edge.
- Decode (`RISC_IUNIT_DECODE_EN`):
  - `ir`=13'h05f1 -> `opcode`=2, `rd`=7, `rs`=6, `rt`=1, `illegal`=0.
  - `ir`=13'h1e00 -> `opcode`=15, `illegal`=1.
